alu_operand_loader: RTL
=======================

// Module: alu_operand_loader
// PURPOSE
//  Write side of the ALU operand path: accepts operands one at a time on a shared
//  WIDTH-bit bus and demultiplexes them, by 4-bit select code, into operand registers A and B.
//  When both operands are held, it presents them to the ALU with a valid/ack handshake.
//  Sits between the operand source (switches/controller) and the ALU input-select logic.
// PARAMETERS
//  WIDTH  6        operand width in bits
//  SEL_W  4        select-code width in bits
// PORTS
//  clk        in   1      system clock, rising edge
//  reset      in   1      asynchronous, active-high reset
//  din        in   WIDTH  operand data bus
//  sel        in   SEL_W  destination code: 4'b0001 -> A, 4'b0010 -> B, all others illegal
//  din_valid  in   1      din/sel valid this cycle
//  din_ready  out  1      loader can accept an operand this cycle
//  a_out      out  WIDTH  operand A register
//  b_out      out  WIDTH  operand B register
//  ops_valid  out  1      A and B both loaded, stable, and presented to the ALU
//  ops_ack    in   1      ALU has consumed the operand pair
//  err        out  1      sticky illegal-select flag (ILLEGAL_SEL_ERR_EN only)
// BEHAVIOUR
//  - Single clock clk; reset asynchronous, active-high.
//  - All outputs registered except din_ready (decoded from state).
//  - Reset: a_out=0, b_out=0, ops_valid=0, err=0, state=EMPTY, din_ready=1.
//  - Accept occurs when din_valid & din_ready; only accepted beats change state or registers.
//  - FSM states EMPTY, HAVE_A, HAVE_B, FULL; din_ready=1 in all states except FULL.
//    EMPTY : sel=A -> load A, go HAVE_A;  sel=B -> load B, go HAVE_B.
//    HAVE_A: sel=A -> overwrite A, stay;  sel=B -> load B, go FULL.
//    HAVE_B: sel=B -> overwrite B, stay;  sel=A -> load A, go FULL.
//    FULL  : ops_valid=1, no accepts. ops_ack -> go EMPTY, ops_valid=0 on the next edge.
//  - Latency: ops_valid rises on the edge after the clock that accepted the second operand.
//  - a_out/b_out hold their values after ack and are not cleared; only reload or reset changes them.
//  - ops_ack while ops_valid=0 is ignored.
//  - Illegal sel on an accepted beat: registers and state unchanged; the beat is consumed.
//  - ops_ack and din_valid in the same FULL cycle: the ack is taken and din is not accepted,
//    because din_ready=0. The source re-presents the beat in EMPTY on the next cycle.
//  - Reset asserted mid-operation: immediate return to reset values; any partial pair is discarded.
// CONFIGURATION
//  Macro ILLEGAL_SEL_ERR_EN:
//  - Defined: an accepted beat with an illegal sel sets err=1.
//    err stays set until reset; loading continues normally.
//  - Undefined: illegal beats are dropped silently, err is tied to 0, and no err flop is built.
// STRUCTURE
//  - Package alu_pkg holds:
//    - SEL_A=4'b0001 and SEL_B=4'b0010 constants, shared with the ALU input-select logic;
//    - the loader state typedef (EMPTY/HAVE_A/HAVE_B/FULL);
//    - the default operand width constant of 6.
//  - One sub-module, operand_reg: a WIDTH-bit register with load enable and async reset.
//    It is instantiated twice, for A and B; the FSM and decode stay in the top.
// TESTING
//  1. Reset, then accept A=6'h15 (sel 0001) and B=6'h2A (sel 0010)
//     -> ops_valid=1 one cycle after the B accept, a_out=15, b_out=2A, din_ready=0.
//  2. In FULL, pulse ops_ack -> next cycle ops_valid=0 and din_ready=1; a_out/b_out still 15/2A.
//  3. Send A=01, then A=3F, then B=00 -> ops_valid=1 with a_out=3F, b_out=00 (overwrite in HAVE_A).
//  4. Send sel=4'b0100 with din=07 -> a_out/b_out unchanged and state unchanged;
//     err=1 if ILLEGAL_SEL_ERR_EN is defined, else err=0.
//  5. Send B=11 first, then A=22 -> FULL with a_out=22, b_out=11;
//     din_valid held in FULL is not accepted until ack.
//  6. Assert reset asynchronously between clock edges while in HAVE_A
//     -> outputs return to 0 immediately, state EMPTY, din_ready=1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the ALU operand path.
//   SEL_A / SEL_B  : one-hot destination codes on the operand bus; the ALU
//                    input-select logic decodes the same values.
//   DEFAULT_WIDTH  : default operand width in bits.
//   loader_state_t : operand loader state (EMPTY, HAVE_A, HAVE_B, FULL).
package alu_pkg;

    localparam int DEFAULT_WIDTH = 6;
    localparam int DEFAULT_SEL_W = 4;

    localparam logic [DEFAULT_SEL_W-1:0] SEL_A = 4'b0001;
    localparam logic [DEFAULT_SEL_W-1:0] SEL_B = 4'b0010;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        HAVE_A = 2'd1,
        HAVE_B = 2'd2,
        FULL   = 2'd3
    } loader_state_t;

endpackage

// File: rtl/operand_reg.sv
// operand_reg
// WIDTH-bit holding register with load enable and asynchronous active-high reset.
// Ports:
//   clk    in   1      rising-edge clock
//   reset  in   1      asynchronous active-high reset, clears q
//   load   in   1      capture d on the next rising edge
//   d      in   WIDTH  data to capture
//   q      out  WIDTH  held value
module operand_reg
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Value only changes on an explicit load; otherwise it holds indefinitely.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/alu_operand_loader.sv
// alu_operand_loader
// Write side of the ALU operand path. Operands arrive one at a time on a shared
// bus and are steered by a select code into operand registers A and B. Once
// both are held, the pair is presented to the ALU with ops_valid until the ALU
// returns ops_ack.
// Optional feature: define ILLEGAL_SEL_ERR_EN to build a sticky err flag that
// is set by any accepted beat carrying an illegal select code. Without it,
// illegal beats are dropped silently and err is tied low.
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous active-high reset
//   din        in   WIDTH  operand data bus
//   sel        in   SEL_W  destination code (SEL_A, SEL_B; others illegal)
//   din_valid  in   1      din/sel valid this cycle
//   din_ready  out  1      an operand can be accepted this cycle
//   a_out      out  WIDTH  operand A register
//   b_out      out  WIDTH  operand B register
//   ops_valid  out  1      both operands held and presented to the ALU
//   ops_ack    in   1      ALU has consumed the operand pair
//   err        out  1      sticky illegal-select flag
module alu_operand_loader
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SEL_W = DEFAULT_SEL_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic [SEL_W-1:0] sel,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             ops_valid,
    input  logic             ops_ack,
    output logic             err
);

    localparam logic [SEL_W-1:0] CODE_A = SEL_W'(SEL_A);
    localparam logic [SEL_W-1:0] CODE_B = SEL_W'(SEL_B);

    loader_state_t state;
    loader_state_t next_state;
    logic          accept;
    logic          is_sel_a;
    logic          is_sel_b;
    logic          load_a;
    logic          load_b;

    assign din_ready = (state != FULL);
    assign accept    = din_valid & din_ready;
    assign is_sel_a  = (sel == CODE_A);
    assign is_sel_b  = (sel == CODE_B);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and load decode. An accepted beat with an illegal code leaves
    // both state and registers untouched; the beat is simply consumed.
    always_comb begin
        next_state = state;
        load_a     = 1'b0;
        load_b     = 1'b0;
        unique case (state)
            EMPTY: begin
                if (accept && is_sel_a) begin
                    load_a     = 1'b1;
                    next_state = HAVE_A;
                end else if (accept && is_sel_b) begin
                    load_b     = 1'b1;
                    next_state = HAVE_B;
                end
            end
            HAVE_A: begin
                if (accept && is_sel_a) begin
                    load_a = 1'b1;
                end else if (accept && is_sel_b) begin
                    load_b     = 1'b1;
                    next_state = FULL;
                end
            end
            HAVE_B: begin
                if (accept && is_sel_b) begin
                    load_b = 1'b1;
                end else if (accept && is_sel_a) begin
                    load_a     = 1'b1;
                    next_state = FULL;
                end
            end
            FULL: begin
                if (ops_ack) begin
                    next_state = EMPTY;
                end
            end
            default: next_state = EMPTY;
        endcase
    end

    // ops_valid is a registered copy of "entering or staying in FULL", so it
    // rises on the edge that captures the second operand and falls on the
    // edge that takes the ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ops_valid <= 1'b0;
        end else begin
            ops_valid <= (next_state == FULL);
        end
    end

    operand_reg #(.WIDTH(WIDTH)) u_reg_a (
        .clk   (clk),
        .reset (reset),
        .load  (load_a),
        .d     (din),
        .q     (a_out)
    );

    operand_reg #(.WIDTH(WIDTH)) u_reg_b (
        .clk   (clk),
        .reset (reset),
        .load  (load_b),
        .d     (din),
        .q     (b_out)
    );

`ifdef ILLEGAL_SEL_ERR_EN
    logic accept_illegal;
    assign accept_illegal = accept & ~is_sel_a & ~is_sel_b;

    // Sticky: once an illegal code has been accepted, only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (accept_illegal) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
